seq_detect_param: RTL and testbench

//   Parametrised streaming sequence detector; successor to the lab's fixed two-input X/Z FSM.

---
 rtl/seq_detect_param.sv | 118 +++++++++++
 tb/tb_seq_detect_param.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Streaming sequence detector: compares the last DEPTH accepted symbols against a
// runtime pattern; X pulses on a match, Z is sticky, match_count saturates.

module seq_slot_cmp #(
  parameter int SYM_W = 2
) (
  input  logic [SYM_W-1:0] hist_sym,
  input  logic [SYM_W-1:0] pat_sym,
  output logic             eq
);
  assign eq = (hist_sym == pat_sym);
endmodule

module seq_detect_param #(
  parameter  int SYM_W  = 2,
  parameter  int DEPTH  = 4,
  parameter  int CNT_W  = 8,
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic [SYM_W*DEPTH-1:0] cfg_pattern,
  input  logic                   cfg_overlap,
  input  logic                   clear,
  output logic                   X,
  output logic                   Z,
  output logic [CNT_W-1:0]       match_count,
  output logic [FILL_W-1:0]      fill_level
);

  typedef enum logic {FILL, RUN} state_e;

  typedef struct packed {
    logic             x;
    logic             z;
    logic [CNT_W-1:0] cnt;
  } stat_t;

  localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

  state_e                        state_q, state_d;
  logic [FILL_W-1:0]             fill_q, fill_d, fill_inc;
  logic [DEPTH-1:0][SYM_W-1:0]   hist_q, hist_d, hist_nxt, pat;
  stat_t                         stat_q, stat_d;
  logic [DEPTH-1:0]              slot_eq;
  logic                          hit;

  assign pat = cfg_pattern;

  // Candidate history: what the shift register holds if this cycle's symbol is taken.
  assign hist_nxt[0] = in_sym;
  generate
    if (DEPTH > 1) begin : g_shift
      assign hist_nxt[DEPTH-1:1] = hist_q[DEPTH-2:0];
    end
  endgenerate

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    seq_slot_cmp #(.SYM_W(SYM_W)) u_cmp (
      .hist_sym (hist_nxt[k]),
      .pat_sym  (pat[k]),
      .eq       (slot_eq[k])
    );
  end

  assign fill_inc = (state_q == RUN) ? FULL : fill_q + FILL_W'(1);
  assign hit      = (fill_inc == FULL) && (&slot_eq);

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    hist_d   = hist_q;
    stat_d   = stat_q;
    stat_d.x = 1'b0;
    if (clear) begin
      state_d = FILL;
      fill_d  = '0;
      stat_d  = '0;
    end else if (in_valid) begin
      hist_d  = hist_nxt;
      fill_d  = fill_inc;
      state_d = (fill_inc == FULL) ? RUN : FILL;
      if (hit) begin
        stat_d.x = 1'b1;
        stat_d.z = 1'b1;
        if (!(&stat_q.cnt)) stat_d.cnt = stat_q.cnt + CNT_W'(1);
        // Non-overlapping mode: next match must be built from DEPTH fresh symbols.
        if (!cfg_overlap) begin
          fill_d  = '0;
          state_d = FILL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      fill_q  <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      stat_q  <= stat_d;
    end
  end

  // History is qualified by fill level, so it needs no reset.
  always_ff @(posedge clk) hist_q <= hist_d;

  assign X           = stat_q.x;
  assign Z           = stat_q.z;
  assign match_count = stat_q.cnt;
  assign fill_level  = fill_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic, checked every
// cycle against a queue-based model, on DEPTH=4 (CNT_W 8 and 2) and DEPTH=1 instances.

module tb_seq_detect_param;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, clear, cfg_overlap;
  logic [1:0] in_sym;
  logic [7:0] cfg_pattern;

  logic       x0, z0, x1, z1, x2, z2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  logic [2:0] fill0, fill1;
  logic [0:0] fill2;

  always #5 clk = ~clk;

  seq_detect_param #(.SYM_W(2), .DEPTH(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clear(clear),
    .X(x0), .Z(z0), .match_count(cnt0), .fill_level(fill0));

  seq_detect_param #(.SYM_W(2), .DEPTH(4), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clear(clear),
    .X(x1), .Z(z1), .match_count(cnt1), .fill_level(fill1));

  seq_detect_param #(.SYM_W(2), .DEPTH(1), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
    .cfg_pattern(cfg_pattern[1:0]), .cfg_overlap(cfg_overlap), .clear(clear),
    .X(x2), .Z(z2), .match_count(cnt2), .fill_level(fill2));

  int n_chk = 0;
  int n_fail = 0;
  int xp0 = 0;
  int xp1 = 0;

  // Model: queue of symbols accepted since the last flush, newest at index 0.
  logic [1:0] mq[$];
  int  mcnt = 0, m1cnt = 0, m1fill = 0;
  bit  mx = 0, mz = 0, m1x = 0, m1z = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx_v);
    return (v > mx_v) ? mx_v : v;
  endfunction

  task automatic model_update();
    bit hit, h1;
    if (!rst_n || clear) begin
      mq.delete();
      mcnt = 0; mz = 0; mx = 0;
      m1cnt = 0; m1z = 0; m1x = 0; m1fill = 0;
    end else if (in_valid) begin
      mq.push_front(in_sym);
      if (mq.size() > D) void'(mq.pop_back());
      hit = (mq.size() == D);
      for (int k = 0; k < D; k++)
        if (hit && mq[k] != cfg_pattern[k*2 +: 2]) hit = 0;
      mx = hit;
      if (hit) begin
        mz = 1; mcnt++;
        if (!cfg_overlap) mq.delete();
      end
      h1 = (in_sym == cfg_pattern[1:0]);
      m1x = h1;
      if (h1) begin m1z = 1; m1cnt++; end
      m1fill = (h1 && !cfg_overlap) ? 0 : 1;
    end else begin
      mx = 0; m1x = 0;
    end
  endtask

  task automatic compare_all();
    chk("x0",    int'(x0),    int'(mx));
    chk("z0",    int'(z0),    int'(mz));
    chk("cnt0",  int'(cnt0),  sat(mcnt, 255));
    chk("fill0", int'(fill0), mq.size());
    chk("x1",    int'(x1),    int'(mx));
    chk("z1",    int'(z1),    int'(mz));
    chk("cnt1",  int'(cnt1),  sat(mcnt, 3));
    chk("fill1", int'(fill1), mq.size());
    chk("x2",    int'(x2),    int'(m1x));
    chk("z2",    int'(z2),    int'(m1z));
    chk("cnt2",  int'(cnt2),  sat(m1cnt, 255));
    chk("fill2", int'(fill2), m1fill);
    if (x0) xp0++;
    if (x1) xp1++;
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic c, input logic r);
    rst_n = r; in_valid = v; in_sym = s; clear = c;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    #1;
  endtask

  task automatic feed(input logic [1:0] s);
    step(1'b1, s, 1'b0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic do_clear();
    step(1'b0, 2'd0, 1'b1, 1'b1);
    xp0 = 0; xp1 = 0;
  endtask

  initial begin
    logic v, c, r;
    logic [1:0] s;
    cfg_pattern = 8'h1B;   // stream 0,1,2,3 oldest first
    cfg_overlap = 1'b1;

    // Reset with a symbol presented
    step(1'b1, 2'd3, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b0);
    chk("rst_x", int'(x0), 0);
    chk("rst_z", int'(z0), 0);
    chk("rst_cnt", int'(cnt0), 0);
    chk("rst_fill", int'(fill0), 0);

    // Basic match
    for (int i = 0; i < 4; i++) begin
      feed(2'(i));
      chk("basic_fill", int'(fill0), i + 1);
      chk("basic_x", int'(x0), (i == 3) ? 1 : 0);
    end
    chk("basic_z", int'(z0), 1);
    chk("basic_cnt", int'(cnt0), 1);
    idle();
    chk("basic_x_drop", int'(x0), 0);

    // Overlapping vs non-overlapping
    cfg_pattern = 8'h55;
    do_clear();
    repeat (7) feed(2'd1);
    chk("ovl1_pulses", xp0, 4);
    chk("ovl1_cnt", int'(cnt0), 4);
    cfg_overlap = 1'b0;
    do_clear();
    repeat (7) feed(2'd1);
    chk("ovl0_pulses", xp0, 1);
    chk("ovl0_cnt", int'(cnt0), 1);
    chk("ovl0_fill", int'(fill0), 3);
    chk("d1_cnt", int'(cnt2), 7);

    // Bubbles between symbols
    cfg_pattern = 8'h1B;
    cfg_overlap = 1'b1;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      feed(2'(i));
      chk("bub_x", int'(x0), (i == 3) ? 1 : 0);
      idle(); chk("bub_idle_x", int'(x0), 0);
      idle(); chk("bub_idle_x", int'(x0), 0);
    end
    chk("bub_pulses", xp0, 1);

    // Counter saturation on the CNT_W=2 instance
    cfg_pattern = 8'h55;
    do_clear();
    repeat (8) feed(2'd1);
    chk("sat_pulses", xp1, 5);
    chk("sat_cnt", int'(cnt1), 3);

    // Clear, then reset, mid-sequence with the completing symbol presented
    cfg_pattern = 8'h1B;
    for (int pass = 0; pass < 2; pass++) begin
      do_clear();
      for (int i = 0; i < 3; i++) feed(2'(i));
      if (pass == 0) step(1'b1, 2'd3, 1'b1, 1'b1);
      else           step(1'b1, 2'd3, 1'b0, 1'b0);
      chk("flush_x", int'(x0), 0);
      chk("flush_fill", int'(fill0), 0);
      chk("flush_z", int'(z0), 0);
      for (int i = 0; i < 4; i++) feed(2'(i));
      chk("flush_rematch", int'(x0), 1);
    end

    // Random traffic, symbols biased toward {0,1} so matches are frequent
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0)
        for (int k = 0; k < D; k++) cfg_pattern[k*2 +: 2] = 2'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) cfg_overlap = ~cfg_overlap;
      r = ($urandom_range(0, 299) != 0);
      c = ($urandom_range(0, 149) == 0);
      v = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
      step(v, s, c, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
